// File: rtl/rv_writeback_q_pkg.sv
// Shared definitions for the writeback stage: load/store function codes and
// the layout of one tag-queue entry.
package rv_writeback_q_pkg;

   localparam logic [2:0] LDST_B  = 3'b000;
   localparam logic [2:0] LDST_H  = 3'b001;
   localparam logic [2:0] LDST_L  = 3'b010;
   localparam logic [2:0] LDST_BU = 3'b100;
   localparam logic [2:0] LDST_HU = 3'b101;

   typedef struct packed {
      logic       is_load;
      logic [2:0] fun;
      logic [1:0] addr;
      logic [4:0] rd;
   } tag_t;

   localparam int TAG_W = $bits(tag_t);

   // Bits that take part in the WAW compare: only queued loads with matching rd.
   localparam tag_t WAW_MASK = '{is_load: 1'b1, fun: 3'b000, addr: 2'b00, rd: 5'h1f};

endpackage

// File: rtl/rv_writeback_q_tag_fifo.sv
// In-order tag queue for outstanding memory ops; every slot is visible so the
// parent can search it for pending destination registers.
module rv_wb_tag_fifo #(
   parameter int DEPTH = 4,
   parameter int WIDTH = 11,
   localparam int PW = $clog2(DEPTH),
   localparam int CW = $clog2(DEPTH+1)
) (
   input  logic                        clk_i,
   input  logic                        rst_i,
   input  logic                        push_i,
   input  logic                        pop_i,
   input  logic [WIDTH-1:0]            data_i,
   output logic                        full_o,
   output logic                        empty_o,
   output logic [CW-1:0]               count_o,
   output logic [WIDTH-1:0]            head_o,
   output logic [DEPTH-1:0][WIDTH-1:0] entries_o,
   output logic [DEPTH-1:0]            valid_o
);

   logic [DEPTH-1:0][WIDTH-1:0] mem_q, mem_d;
   logic [PW-1:0]               wr_ptr_q, wr_ptr_d, rd_ptr_q, rd_ptr_d;
   logic [CW-1:0]               count_q, count_d;
   logic                        do_push, do_pop;
   logic [PW-1:0]               off;

   assign full_o    = (count_q == CW'(DEPTH));
   assign empty_o   = (count_q == '0);
   assign count_o   = count_q;
   assign head_o    = mem_q[rd_ptr_q];
   assign entries_o = mem_q;

   // A pop in the same cycle never makes room for a push into a full queue.
   assign do_push = push_i & ~full_o;
   assign do_pop  = pop_i & ~empty_o;

   always_comb begin
      mem_d    = mem_q;
      wr_ptr_d = wr_ptr_q;
      rd_ptr_d = rd_ptr_q;
      if (do_push) begin
         mem_d[wr_ptr_q] = data_i;
         wr_ptr_d        = wr_ptr_q + 1'b1;
      end
      if (do_pop) begin
         rd_ptr_d = rd_ptr_q + 1'b1;
      end
      count_d = count_q + CW'(do_push) - CW'(do_pop);
   end

   always_comb begin
      valid_o = '0;
      off     = '0;
      for (int i = 0; i < DEPTH; i++) begin
         off        = PW'(i) - rd_ptr_q;
         valid_o[i] = (CW'(off) < count_q);
      end
   end

   always_ff @(posedge clk_i or posedge rst_i) begin
      if (rst_i) begin
         mem_q    <= '0;
         wr_ptr_q <= '0;
         rd_ptr_q <= '0;
         count_q  <= '0;
      end else begin
         mem_q    <= mem_d;
         wr_ptr_q <= wr_ptr_d;
         rd_ptr_q <= rd_ptr_d;
         count_q  <= count_d;
      end
   end

endmodule

// File: rtl/rv_writeback_q.sv
// Writeback stage: retires memory responses in issue order, extracts load data
// and shares the single register-file write port with ALU results.
module rv_writeback_q
   import rv_writeback_q_pkg::*;
#(
   parameter int DEPTH = 4
) (
   input  logic                         clk_i,
   input  logic                         rst_i,
   input  logic                         w_stall_i,
   output logic                         w_stall_req_o,
   input  logic                         x_valid_i,
   input  logic                         x_load_i,
   input  logic                         x_store_i,
   input  logic                         x_fence_i,
   input  logic [2:0]                   x_fun_i,
   input  logic [1:0]                   x_dm_addr_i,
   input  logic [4:0]                   x_rd_i,
   input  logic [31:0]                  x_rd_value_i,
   input  logic                         x_rd_write_i,
   input  logic [31:0]                  dm_data_l_i,
   input  logic                         dm_load_done_i,
   input  logic                         dm_store_done_i,
   output logic [31:0]                  rf_rd_value_o,
   output logic [4:0]                   rf_rd_o,
   output logic                         rf_rd_write_o,
   output logic [$clog2(DEPTH+1)-1:0]   pending_o,
   output logic                         err_o
);

   localparam int CW = $clog2(DEPTH+1);

   tag_t                        head, push_tag, waw_key;
   logic [TAG_W-1:0]            head_bits;
   logic [DEPTH-1:0][TAG_W-1:0] entries;
   logic [DEPTH-1:0]            valid;
   logic                        full, empty;
   logic [CW-1:0]               count;
   logic                        is_mem, resp, resp_err, load_ret, store_ret, pop, push;
   logic                        accept, waw_hit, stall_req, alu_write;
   logic [7:0]                  ld_byte;
   logic [15:0]                 ld_half;
   logic [31:0]                 ld_value;
   logic                        err_q, err_d;

   assign head      = tag_t'(head_bits);
   assign push_tag  = '{is_load: x_load_i, fun: x_fun_i, addr: x_dm_addr_i, rd: x_rd_i};
   assign waw_key   = '{is_load: 1'b1, fun: 3'b000, addr: 2'b00, rd: x_rd_i};
   assign pending_o = count;
   assign err_o     = err_q;

   rv_wb_tag_fifo #(.DEPTH(DEPTH), .WIDTH(TAG_W)) u_tag_fifo (
      .clk_i     (clk_i),
      .rst_i     (rst_i),
      .push_i    (push),
      .pop_i     (pop),
      .data_i    (push_tag),
      .full_o    (full),
      .empty_o   (empty),
      .count_o   (count),
      .head_o    (head_bits),
      .entries_o (entries),
      .valid_o   (valid)
   );

   // A response that does not match the head (or arrives with nothing queued) is dropped.
   always_comb begin
      resp      = dm_load_done_i | dm_store_done_i;
      load_ret  = dm_load_done_i & ~dm_store_done_i & ~empty & head.is_load;
      store_ret = dm_store_done_i & ~dm_load_done_i & ~empty & ~head.is_load;
      pop       = load_ret | store_ret;
      resp_err  = resp & ~pop;
      err_d     = err_q | resp_err;
   end

   always_comb begin
      waw_hit = 1'b0;
      for (int i = 0; i < DEPTH; i++) begin
         if (valid[i] && (((entries[i] ^ waw_key) & WAW_MASK) == '0)) begin
            waw_hit = 1'b1;
         end
      end
   end

   always_comb begin
      is_mem    = x_load_i | x_store_i;
      stall_req = x_valid_i & ~rst_i &
                  ((is_mem & full) |
                   (x_rd_write_i & load_ret) |
                   (x_rd_write_i & (x_rd_i != 5'd0) & waw_hit) |
                   (x_fence_i & ~empty));
      accept    = x_valid_i & ~w_stall_i & ~stall_req;
      push      = accept & is_mem;
      alu_write = accept & x_rd_write_i & ~load_ret & (x_rd_i != 5'd0);
   end

   always_comb begin
      ld_byte  = 8'h00;
      ld_value = 32'h0;
      case (head.addr)
         2'd0:    ld_byte = dm_data_l_i[7:0];
         2'd1:    ld_byte = dm_data_l_i[15:8];
         2'd2:    ld_byte = dm_data_l_i[23:16];
         default: ld_byte = dm_data_l_i[31:24];
      endcase
      ld_half = head.addr[1] ? dm_data_l_i[31:16] : dm_data_l_i[15:0];
      case (head.fun)
         LDST_B:  ld_value = {{24{ld_byte[7]}}, ld_byte};
         LDST_BU: ld_value = {24'h0, ld_byte};
         LDST_H:  ld_value = {{16{ld_half[15]}}, ld_half};
         LDST_HU: ld_value = {16'h0, ld_half};
         LDST_L:  ld_value = dm_data_l_i;
         default: ld_value = 32'h0;
      endcase
   end

   // Load returns own the write port; the ALU gets it only when no load retires.
   always_comb begin
      rf_rd_write_o = 1'b0;
      rf_rd_o       = 5'd0;
      rf_rd_value_o = 32'h0;
      if (!rst_i) begin
         if (load_ret) begin
            rf_rd_write_o = (head.rd != 5'd0);
            rf_rd_o       = head.rd;
            rf_rd_value_o = ld_value;
         end else if (alu_write) begin
            rf_rd_write_o = 1'b1;
            rf_rd_o       = x_rd_i;
            rf_rd_value_o = x_rd_value_i;
         end
      end
   end

   assign w_stall_req_o = stall_req;

   always_ff @(posedge clk_i or posedge rst_i) begin
      if (rst_i) begin
         err_q <= 1'b0;
      end else begin
         err_q <= err_d;
      end
   end

endmodule

// File: tb/tb_rv_writeback_q.sv
// Bench for rv_writeback_q: directed scenarios plus a randomized run, all
// checked against a queue-based reference model of the writeback rules.
module tb_rv_writeback_q;
   import rv_writeback_q_pkg::*;

   localparam int DEPTH = 4;

   logic        clk = 1'b0;
   logic        rst_i;
   logic        w_stall_i, w_stall_req_o;
   logic        x_valid_i, x_load_i, x_store_i, x_fence_i, x_rd_write_i;
   logic [2:0]  x_fun_i;
   logic [1:0]  x_dm_addr_i;
   logic [4:0]  x_rd_i, rf_rd_o;
   logic [31:0] x_rd_value_i, dm_data_l_i, rf_rd_value_o;
   logic        dm_load_done_i, dm_store_done_i, rf_rd_write_o, err_o;
   logic [$clog2(DEPTH+1)-1:0] pending_o;

   typedef struct {
      bit         is_load;
      logic [2:0] fun;
      logic [1:0] addr;
      logic [4:0] rd;
   } op_t;

   op_t mq[$];
   bit  m_err;
   int  n_checks = 0;
   int  n_fail = 0;
   bit  p_pop, p_push, p_err;
   op_t p_op;

   always #5 clk = ~clk;

   rv_writeback_q #(.DEPTH(DEPTH)) dut (
      .clk_i           (clk),
      .rst_i           (rst_i),
      .w_stall_i       (w_stall_i),
      .w_stall_req_o   (w_stall_req_o),
      .x_valid_i       (x_valid_i),
      .x_load_i        (x_load_i),
      .x_store_i       (x_store_i),
      .x_fence_i       (x_fence_i),
      .x_fun_i         (x_fun_i),
      .x_dm_addr_i     (x_dm_addr_i),
      .x_rd_i          (x_rd_i),
      .x_rd_value_i    (x_rd_value_i),
      .x_rd_write_i    (x_rd_write_i),
      .dm_data_l_i     (dm_data_l_i),
      .dm_load_done_i  (dm_load_done_i),
      .dm_store_done_i (dm_store_done_i),
      .rf_rd_value_o   (rf_rd_value_o),
      .rf_rd_o         (rf_rd_o),
      .rf_rd_write_o   (rf_rd_write_o),
      .pending_o       (pending_o),
      .err_o           (err_o)
   );

   task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      n_checks++;
      assert (obs === exp) else begin
         n_fail++;
         $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
      end
   endtask

   // Load data extraction from the function code, by shifting and masking.
   function automatic logic [31:0] ref_extract(logic [2:0] fun, logic [1:0] addr, logic [31:0] d);
      logic [31:0] b, h;
      b = (d >> (8 * addr)) & 32'hFF;
      h = (d >> (16 * addr[1])) & 32'hFFFF;
      case (fun)
         LDST_B:  return (b >= 32'd128) ? b - 32'd256 : b;
         LDST_BU: return b;
         LDST_H:  return (h >= 32'd32768) ? h - 32'd65536 : h;
         LDST_HU: return h;
         LDST_L:  return d;
         default: return 32'h0;
      endcase
   endfunction

   task automatic idle();
      w_stall_i       = 1'b0;
      x_valid_i       = 1'b0;
      x_load_i        = 1'b0;
      x_store_i       = 1'b0;
      x_fence_i       = 1'b0;
      x_rd_write_i    = 1'b0;
      x_fun_i         = 3'd0;
      x_dm_addr_i     = 2'd0;
      x_rd_i          = 5'd0;
      x_rd_value_i    = 32'h0;
      dm_data_l_i     = 32'h0;
      dm_load_done_i  = 1'b0;
      dm_store_done_i = 1'b0;
   endtask

   task automatic settle_check(input string tag);
      int          n;
      bit          ok_ld, ok_st, waw, stall, acc, ewe;
      logic [4:0]  erd;
      logic [31:0] ev;
      #1;
      n = mq.size();
      ok_ld = 1'b0;
      ok_st = 1'b0;
      if (n > 0) begin
         ok_ld = dm_load_done_i && !dm_store_done_i && mq[0].is_load;
         ok_st = dm_store_done_i && !dm_load_done_i && !mq[0].is_load;
      end
      waw = 1'b0;
      foreach (mq[i]) if (mq[i].is_load && mq[i].rd == x_rd_i) waw = 1'b1;
      stall = x_valid_i && (((x_load_i || x_store_i) && n == DEPTH) ||
                            (x_rd_write_i && ok_ld) ||
                            (x_rd_write_i && x_rd_i != 5'd0 && waw) ||
                            (x_fence_i && n != 0));
      acc = x_valid_i && !w_stall_i && !stall;
      ewe = 1'b0;
      erd = 5'd0;
      ev  = 32'h0;
      if (ok_ld) begin
         ewe = (mq[0].rd != 5'd0);
         erd = mq[0].rd;
         ev  = ref_extract(mq[0].fun, mq[0].addr, dm_data_l_i);
      end else if (acc && x_rd_write_i && x_rd_i != 5'd0) begin
         ewe = 1'b1;
         erd = x_rd_i;
         ev  = x_rd_value_i;
      end
      chk({tag, "/stall_req"}, w_stall_req_o, stall);
      chk({tag, "/rf_we"}, rf_rd_write_o, ewe);
      if (ewe) begin
         chk({tag, "/rf_rd"}, rf_rd_o, erd);
         chk({tag, "/rf_val"}, rf_rd_value_o, ev);
      end
      chk({tag, "/pending"}, pending_o, n);
      chk({tag, "/err"}, err_o, m_err);
      p_pop  = ok_ld || ok_st;
      p_push = acc && (x_load_i || x_store_i);
      p_err  = (dm_load_done_i || dm_store_done_i) && !p_pop;
      p_op   = '{is_load: x_load_i, fun: x_fun_i, addr: x_dm_addr_i, rd: x_rd_i};
   endtask

   task automatic advance();
      @(posedge clk);
      if (p_pop) void'(mq.pop_front());
      if (p_push) mq.push_back(p_op);
      if (p_err) m_err = 1'b1;
      #1;
   endtask

   task automatic tick(input string tag);
      settle_check(tag);
      advance();
   endtask

   task automatic issue_mem(input bit ld, input logic [2:0] fun, input logic [1:0] addr, input logic [4:0] rd);
      idle();
      x_valid_i   = 1'b1;
      x_load_i    = ld;
      x_store_i   = !ld;
      x_fun_i     = fun;
      x_dm_addr_i = addr;
      x_rd_i      = rd;
   endtask

   task automatic set_alu(input logic [4:0] rd, input logic [31:0] val);
      x_valid_i    = 1'b1;
      x_rd_write_i = 1'b1;
      x_rd_i       = rd;
      x_rd_value_i = val;
   endtask

   initial begin
      idle();
      rst_i = 1'b1;
      m_err = 1'b0;

      // Outputs are forced quiet while reset is high, even with an ALU write and a response present.
      set_alu(5'd3, 32'h5);
      dm_load_done_i = 1'b1;
      #2;
      chk("rst/stall_req", w_stall_req_o, 1'b0);
      chk("rst/rf_we", rf_rd_write_o, 1'b0);
      chk("rst/rf_rd", rf_rd_o, 5'd0);
      chk("rst/rf_val", rf_rd_value_o, 32'h0);
      chk("rst/pending", pending_o, 0);
      chk("rst/err", err_o, 1'b0);
      @(posedge clk);
      @(posedge clk);
      #1;
      rst_i = 1'b0;
      idle();

      // LB at addr 3 and LHU at addr 2, data written in the response cycle.
      issue_mem(1'b1, LDST_B, 2'd3, 5'd7);
      tick("lb_issue");
      idle();
      dm_load_done_i = 1'b1;
      dm_data_l_i    = 32'h80FF_0000;
      settle_check("lb_ret");
      chk("lb_const_val", rf_rd_value_o, 32'hFFFF_FF80);
      chk("lb_const_rd", rf_rd_o, 5'd7);
      advance();
      issue_mem(1'b1, LDST_HU, 2'd2, 5'd8);
      tick("lhu_issue");
      idle();
      dm_load_done_i = 1'b1;
      dm_data_l_i    = 32'h8001_1234;
      settle_check("lhu_ret");
      chk("lhu_const_val", rf_rd_value_o, 32'h0000_8001);
      advance();

      // Fill the queue; the fifth op waits, a same-cycle pop does not free the slot.
      for (int i = 1; i <= DEPTH; i++) begin
         issue_mem(1'b1, LDST_L, 2'd0, 5'(i));
         tick("fill");
      end
      issue_mem(1'b1, LDST_L, 2'd0, 5'd9);
      settle_check("full_wait");
      chk("full_const_stall", w_stall_req_o, 1'b1);
      chk("full_const_pending", pending_o, DEPTH);
      advance();
      dm_load_done_i = 1'b1;
      dm_data_l_i    = 32'h1234_5678;
      settle_check("full_pop");
      chk("full_pop_const_stall", w_stall_req_o, 1'b1);
      advance();
      dm_load_done_i = 1'b0;
      settle_check("full_accept");
      chk("full_accept_const", w_stall_req_o, 1'b0);
      advance();
      for (int i = 0; i < DEPTH; i++) begin
         idle();
         dm_load_done_i = 1'b1;
         dm_data_l_i    = $urandom;
         tick("drain");
      end

      // WAW interlock on x5; x6 proceeds.
      issue_mem(1'b1, LDST_L, 2'd0, 5'd5);
      tick("waw_issue");
      idle();
      set_alu(5'd5, 32'hAAAA_0005);
      settle_check("waw_stall");
      chk("waw_const_stall", w_stall_req_o, 1'b1);
      advance();
      tick("waw_stall2");
      idle();
      set_alu(5'd6, 32'hBBBB_0006);
      settle_check("waw_other");
      chk("waw_other_const_rd", rf_rd_o, 5'd6);
      advance();
      idle();
      set_alu(5'd5, 32'hAAAA_0005);
      dm_load_done_i = 1'b1;
      dm_data_l_i    = 32'hCAFE_F00D;
      settle_check("waw_ret");
      chk("waw_ret_const_val", rf_rd_value_o, 32'hCAFE_F00D);
      advance();
      dm_load_done_i = 1'b0;
      settle_check("waw_release");
      chk("waw_release_const_val", rf_rd_value_o, 32'hAAAA_0005);
      advance();

      // Port conflict with a non-conflicting rd.
      issue_mem(1'b1, LDST_H, 2'd1, 5'd10);
      tick("pc_issue");
      idle();
      set_alu(5'd11, 32'h0000_1111);
      dm_load_done_i = 1'b1;
      dm_data_l_i    = 32'h0000_F234;
      settle_check("pc_conflict");
      chk("pc_const_stall", w_stall_req_o, 1'b1);
      chk("pc_const_val", rf_rd_value_o, 32'hFFFF_F234);
      advance();
      dm_load_done_i = 1'b0;
      settle_check("pc_alu");
      chk("pc_alu_const_rd", rf_rd_o, 5'd11);
      advance();

      // Stray store response with an empty queue.
      idle();
      dm_store_done_i = 1'b1;
      tick("stray_store");
      idle();
      settle_check("stray_after");
      chk("stray_const_err", err_o, 1'b1);
      advance();

      // Fence with two stores pending.
      issue_mem(1'b0, LDST_L, 2'd0, 5'd0);
      tick("fence_st0");
      issue_mem(1'b0, LDST_L, 2'd0, 5'd0);
      tick("fence_st1");
      idle();
      x_valid_i = 1'b1;
      x_fence_i = 1'b1;
      tick("fence_wait");
      dm_store_done_i = 1'b1;
      tick("fence_ret0");
      settle_check("fence_ret1");
      chk("fence_ret1_const", w_stall_req_o, 1'b1);
      advance();
      dm_store_done_i = 1'b0;
      settle_check("fence_go");
      chk("fence_go_const", w_stall_req_o, 1'b0);
      advance();

      // Asynchronous reset mid-cycle with three loads outstanding.
      for (int i = 0; i < 3; i++) begin
         issue_mem(1'b1, LDST_L, 2'd0, 5'(12 + i));
         tick("arst_fill");
      end
      idle();
      dm_load_done_i = 1'b1;
      dm_data_l_i    = 32'h1111_2222;
      #3;
      rst_i = 1'b1;
      #1;
      chk("arst_pending", pending_o, 0);
      chk("arst_rf_we", rf_rd_write_o, 1'b0);
      chk("arst_err", err_o, 1'b0);
      mq.delete();
      m_err = 1'b0;
      @(posedge clk);
      #1;
      rst_i = 1'b0;
      idle();
      dm_load_done_i = 1'b1;
      tick("arst_late_resp");
      idle();
      settle_check("arst_after");
      chk("arst_const_err", err_o, 1'b1);
      advance();

      // Clean reset, then a randomized run.
      rst_i = 1'b1;
      mq.delete();
      m_err = 1'b0;
      @(posedge clk);
      #1;
      rst_i = 1'b0;
      for (int c = 0; c < 400; c++) begin
         int kind;
         idle();
         w_stall_i = ($urandom_range(0, 9) == 0);
         if ($urandom_range(0, 3) != 0) begin
            kind = $urandom_range(0, 9);
            x_valid_i = 1'b1;
            if (kind <= 2) begin
               x_load_i    = 1'b1;
               x_fun_i     = 3'($urandom_range(0, 7));
               x_dm_addr_i = 2'($urandom_range(0, 3));
               x_rd_i      = 5'($urandom_range(0, 7));
            end else if (kind <= 4) begin
               x_store_i = 1'b1;
            end else if (kind <= 8) begin
               x_rd_write_i = ($urandom_range(0, 4) != 0);
               x_rd_i       = 5'($urandom_range(0, 7));
               x_rd_value_i = $urandom;
            end else begin
               x_fence_i = 1'b1;
            end
         end
         if (mq.size() > 0 && $urandom_range(0, 2) != 0) begin
            if (mq[0].is_load) dm_load_done_i = 1'b1;
            else dm_store_done_i = 1'b1;
            dm_data_l_i = $urandom;
         end
         tick("rnd");
      end

      $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
      $finish;
   end

endmodule

// File: doc/rv_writeback_q.md
# rv_writeback_q

Parametrised writeback stage for a pipelined data bus that can have up to DEPTH loads/stores outstanding. It sits between execute and the register file. Each memory op is logged in an in-order tag queue at issue. Returning load data is aligned and sign/zero-extended, then written to the register file. ALU results share the single write port under fixed arbitration and a WAW interlock.

## Interface
- DEPTH, 4 — max outstanding memory ops; power of two, 2..16.
- clk_i  in  1  clock; all state on rising edge.
- rst_i  in  1  reset, asynchronous, active-high.
- w_stall_i  in  1  pipeline stall from control; blocks acceptance of the current X op.
- w_stall_req_o  out  1  this stage cannot accept the current X op this cycle.
- x_valid_i  in  1  X op present.
- x_load_i, x_store_i  in  1  memory op type; mutually exclusive.
- x_fence_i  in  1  drain request.
- x_fun_i  in  3  LDST_B/BU/H/HU/L code.
- x_dm_addr_i  in  2  low address bits.
- x_rd_i  in  5  destination register.
- x_rd_value_i  in  32  ALU result.
- x_rd_write_i  in  1  ALU op writes rd.
- dm_data_l_i  in  32  load data.
- dm_load_done_i  in  1  one load response.
- dm_store_done_i  in  1  one store response.
- rf_rd_value_o  out  32  register-file write data.
- rf_rd_o  out  5  register-file write address.
- rf_rd_write_o  out  1  register-file write enable.
- pending_o  out  $clog2(DEPTH+1)  outstanding op count.
- err_o  out  1  sticky protocol error.

## Operation
- **Accept condition:** an X op is accepted when x_valid_i && !w_stall_i && !w_stall_req_o.
- **Queue entry:** an accepted load or store pushes {is_load, fun, addr[1:0], rd} into the tag queue.
- **Response retirement:**
  - Responses retire strictly in order from the queue head.
  - At most one response arrives per cycle.
  - Responses retire regardless of w_stall_i.
- **Load return:** rf_rd_write_o=1, rf_rd_o=head.rd, rf_rd_value_o=extracted value.
  - B/BU select byte addr[1:0].
  - H/HU select half addr[1].
  - L passes the full word.
  - B/H sign-extend; BU/HU zero-extend.
  - Undefined fun yields 0.
  - If head.rd==0, rf_rd_write_o=0.
- **Store return:** no register-file write.
- **ALU write:** when accepted, x_rd_write_i=1, no load return this cycle, and x_rd_i≠0, the ALU result is written: rf_rd_value_o=x_rd_value_i, rf_rd_o=x_rd_i.
- **Stall request** (w_stall_req_o=1, only while x_valid_i) when any of:
  - a memory op arrives and the queue is full; a simultaneous pop does not free the slot;
  - x_rd_write_i and a load return occurs this cycle (port conflict);
  - x_rd_write_i and x_rd_i≠0 matches rd of any queued load (WAW);
  - x_fence_i and pending_o≠0.
- **Protocol errors:** err_o is set when
  - a response arrives with the queue empty;
  - a response type mismatches head.is_load;
  - dm_load_done_i and dm_store_done_i are asserted together.
  
  The offending response is dropped and the queue is unchanged. err_o clears only on reset.

## Timing
- Load data reaches the register-file write port in the same cycle as dm_load_done_i (combinational); queue pop takes effect on the next edge.
- Enqueue is visible to the WAW check and pending_o from the next cycle.
- A response may retire in the cycle after its issue, but never in the issue cycle itself. A response in the issue cycle with an empty queue is an error.
- Push and pop in the same cycle leave pending_o unchanged.
- **Reset:**
  - Queue pointers, count and err_o go to 0.
  - While rst_i is high: rf_rd_write_o=0, w_stall_req_o=0, rf_rd_o=0, rf_rd_value_o=0.
  - Reset mid-operation discards all outstanding tags; responses arriving after reset flag err_o.
- Pointers wrap modulo DEPTH; count distinguishes full from empty.

## Structure
- LDST_* codes stay in the shared rv_defs include.
- Add a shared constant for the tag entry layout there.
- Sub-module rv_wb_tag_fifo (DEPTH, WIDTH):
  - push, pop, full, empty, count, head data;
  - exposes all entries for the WAW compare.
- The WAW compare and the extraction mux live in the top module.

## Test plan
- LB at addr 2'b11, data 32'h80FF_0000 → value 32'hFFFF_FF80, rd written the same cycle as done; LHU at addr 2'b10, data 32'h8001_1234 → 32'h0000_8001.
- DEPTH=4: issue 4 loads back-to-back with no responses → 5th memory op gets w_stall_req_o=1 and pending_o=4; one response → the 5th is accepted on the following cycle.
- Load to x5 outstanding, then ALU write to x5 → stalled until the load returns; ALU write to x6 proceeds immediately.
- ALU write coincides with a load return → rf carries load data, w_stall_req_o=1; ALU result written the next cycle.
- dm_store_done_i with an empty queue → err_o=1, no rf write, pending_o stays 0; fence with 2 pending → stall until both return.
- Assert rst_i asynchronously with 3 pending and mid-cycle → pending_o=0, rf_rd_write_o=0 immediately; later response sets err_o.
